// File: rtl/robot_frame_ctrl_if.sv
// Bundle of scan-position inputs, the move-command handshake and the sprite
// position/status outputs shared between the control logic and the renderer.
interface robot_frame_ctrl_if;
  logic [9:0] pix_y;
  logic       video_on;
  logic       cmd_valid;
  logic [1:0] cmd_dir;
  logic       cmd_ready;
  logic [4:0] robot_tx;
  logic [3:0] robot_ty;
  logic       move_done;
  logic       move_blocked;
  logic       frame_tick;

  modport master (
    output pix_y, video_on, cmd_valid, cmd_dir,
    input  cmd_ready, robot_tx, robot_ty, move_done, move_blocked, frame_tick
  );

  modport slave (
    input  pix_y, video_on, cmd_valid, cmd_dir,
    output cmd_ready, robot_tx, robot_ty, move_done, move_blocked, frame_tick
  );
endinterface

// File: rtl/robot_frame_ctrl.sv
// Robot sprite position scheduler: accepts one move command at a time and
// commits it only in vertical blank, clamped to the tile grid and wall column.
module robot_frame_ctrl #(
  parameter int MAX_X       = 640,
  parameter int MAX_Y       = 480,
  parameter int TILES_X     = 20,
  parameter int TILES_Y     = 15,
  parameter int WALL_TX     = 1,
  parameter int STEP_FRAMES = 4,
  parameter int INIT_TX     = 0,
  parameter int INIT_TY     = 0
) (
  input  logic               clock_50,
  input  logic               reset,
  robot_frame_ctrl_if.slave  bus
);

  // The grid never extends past the visible area of 32 px tiles.
  localparam int COLS = (TILES_X < MAX_X / 32) ? TILES_X : MAX_X / 32;
  localparam int ROWS = (TILES_Y < MAX_Y / 32) ? TILES_Y : MAX_Y / 32;

  localparam logic signed [5:0] COLS_S  = 6'(COLS);
  localparam logic signed [5:0] ROWS_S  = 6'(ROWS);
  localparam logic signed [5:0] WALL_S  = 6'(WALL_TX);
  localparam logic        [9:0] MAX_Y_L = 10'(MAX_Y);
  localparam logic        [3:0] STEP_L  = 4'(STEP_FRAMES);
  localparam logic        [3:0] STEP_M1 = 4'(STEP_FRAMES - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_VB,
    APPLY,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic        [1:0] dir_q, dir_d;
  logic        [4:0] tx_q, tx_d;
  logic        [3:0] ty_q, ty_d;
  logic        [3:0] cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              blk_q, blk_d;
  logic              vb_q;
  logic              tick_q;
  logic              vb;
  logic signed [5:0] tgt_x, tgt_y;
  logic              blocked;

  assign vb = (bus.pix_y >= MAX_Y_L);

  always_ff @(posedge clock_50 or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      dir_q   <= 2'd0;
      tx_q    <= 5'(INIT_TX);
      ty_q    <= 4'(INIT_TY);
      cnt_q   <= 4'd0;
      done_q  <= 1'b0;
      blk_q   <= 1'b0;
      vb_q    <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      tx_q    <= tx_d;
      ty_q    <= ty_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      blk_q   <= blk_d;
      vb_q    <= vb;
      tick_q  <= vb & ~vb_q;
    end
  end

  // Signed target so a step below tile 0 shows up as negative instead of wrapping.
  always_comb begin
    tgt_x = $signed({1'b0, tx_q});
    tgt_y = $signed({2'b00, ty_q});
    case (dir_q)
      2'd0:    tgt_y = $signed({2'b00, ty_q}) - 6'sd1;
      2'd1:    tgt_y = $signed({2'b00, ty_q}) + 6'sd1;
      2'd2:    tgt_x = $signed({1'b0, tx_q}) - 6'sd1;
      default: tgt_x = $signed({1'b0, tx_q}) + 6'sd1;
    endcase
    blocked = (tgt_x < 6'sd0) || (tgt_x >= COLS_S) ||
              (tgt_y < 6'sd0) || (tgt_y >= ROWS_S) ||
              (tgt_x == WALL_S) || bus.video_on;
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    tx_d    = tx_q;
    ty_d    = ty_q;
    done_d  = 1'b0;
    blk_d   = 1'b0;
    cnt_d   = cnt_q;

    if (tick_q && (cnt_q < STEP_L)) begin
      cnt_d = cnt_q + 4'd1;
    end

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          dir_d   = bus.cmd_dir;
          state_d = WAIT_VB;
        end
      end
      WAIT_VB: begin
        if (tick_q && (cnt_q >= STEP_M1)) begin
          state_d = APPLY;
        end
      end
      APPLY: begin
        if (blocked) begin
          blk_d = 1'b1;
        end else begin
          done_d = 1'b1;
          tx_d   = tgt_x[4:0];
          ty_d   = tgt_y[3:0];
        end
        state_d = DONE;
      end
      default: begin
        cnt_d   = 4'd0;
        state_d = IDLE;
      end
    endcase
  end

  assign bus.cmd_ready    = (state_q == IDLE);
  assign bus.robot_tx     = tx_q;
  assign bus.robot_ty     = ty_q;
  assign bus.move_done    = done_q;
  assign bus.move_blocked = blk_q;
  assign bus.frame_tick   = tick_q;

endmodule

// File: tb/tb_robot_frame_ctrl.sv
// Directed scoreboard bench for robot_frame_ctrl: stimulus pushes hand-computed
// move results, a negedge monitor pops and compares on every done/blocked pulse.
module tb_robot_frame_ctrl;

  typedef struct packed {
    logic       done;
    logic [4:0] tx;
    logic [3:0] ty;
  } exp_t;

  logic clock_50 = 1'b0;
  logic reset;
  bit   genOn = 1'b0;
  bit   illegalVideo = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   tickSince = 0;
  exp_t sbQ[$];

  always #5 clock_50 = ~clock_50;

  robot_frame_ctrl_if bus();

  robot_frame_ctrl #(
    .INIT_TX(2),
    .INIT_TY(5)
  ) dut (
    .clock_50(clock_50),
    .reset(reset),
    .bus(bus)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  task automatic timeoutFail(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s timed out waiting for DUT", name);
  endtask

  // Waits for cmd_ready and requires that the cycle just before it carried a pulse.
  task automatic waitReady(input string name);
    bit seen = 1'b0;
    bit prevPulse = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clock_50);
      if (bus.cmd_ready) begin
        seen = 1'b1;
        break;
      end
      prevPulse = bus.move_done | bus.move_blocked;
    end
    if (!seen) timeoutFail(name);
    else checkOutput(name, int'(prevPulse), 1);
  endtask

  task automatic applyStimulus(input logic [1:0] dir, input logic expDone,
                               input int expTx, input int expTy);
    exp_t e;
    @(negedge clock_50);
    e.done = expDone;
    e.tx   = 5'(expTx);
    e.ty   = 4'(expTy);
    sbQ.push_back(e);
    bus.cmd_valid = 1'b1;
    bus.cmd_dir   = dir;
    @(posedge clock_50);
    #1;
    bus.cmd_valid = 1'b0;
    waitReady("ready_after_pulse");
  endtask

  // Abstract frame: 6 active lines then 6 vblank lines, one line per clock.
  initial begin
    forever begin
      if (genOn) begin
        for (int i = 0; i < 6; i++) begin
          @(posedge clock_50);
          #1;
          bus.pix_y    = 10'(100 + i);
          bus.video_on = 1'b1;
        end
        for (int i = 0; i < 6; i++) begin
          @(posedge clock_50);
          #1;
          bus.pix_y    = 10'(480 + i);
          bus.video_on = illegalVideo;
        end
      end else begin
        @(posedge clock_50);
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clock_50);
      if (reset) begin
        tickSince = 0;
      end else begin
        if (bus.frame_tick) tickSince++;
        if (bus.move_done || bus.move_blocked) begin
          checkOutput("pulse_exclusive", int'(bus.move_done & bus.move_blocked), 0);
          checkOutput("pulse_vs_ready", int'(bus.cmd_ready), 0);
          if (sbQ.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_pulse done=%0d blocked=%0d required=no pulse",
                     bus.move_done, bus.move_blocked);
          end else begin
            e = sbQ.pop_front();
            checkOutput("pulse_done", int'(bus.move_done), int'(e.done));
            checkOutput("pulse_blocked", int'(bus.move_blocked), int'(!e.done));
            checkOutput("pulse_tx", int'(bus.robot_tx), int'(e.tx));
            checkOutput("pulse_ty", int'(bus.robot_ty), int'(e.ty));
            checkOutput("frames_per_move", tickSince, 4);
          end
          tickSince = 0;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int ticks;
    int misaligned;
    exp_t e;

    reset         = 1'b1;
    bus.pix_y     = 10'd0;
    bus.video_on  = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_dir   = 2'd0;
    repeat (3) @(posedge clock_50);
    #1;
    checkOutput("reset_tx", int'(bus.robot_tx), 2);
    checkOutput("reset_ty", int'(bus.robot_ty), 5);
    checkOutput("reset_ready", int'(bus.cmd_ready), 1);
    checkOutput("reset_done", int'(bus.move_done), 0);
    checkOutput("reset_blocked", int'(bus.move_blocked), 0);
    checkOutput("reset_tick", int'(bus.frame_tick), 0);
    @(negedge clock_50);
    reset = 1'b0;
    genOn = 1'b1;

    applyStimulus(2'd1, 1'b1, 2, 6);
    applyStimulus(2'd2, 1'b0, 2, 6);

    // Held cmd_valid: second right is taken in the first IDLE cycle after DONE.
    @(negedge clock_50);
    e = '{done: 1'b1, tx: 5'd3, ty: 4'd6};
    sbQ.push_back(e);
    e = '{done: 1'b1, tx: 5'd4, ty: 4'd6};
    sbQ.push_back(e);
    bus.cmd_valid = 1'b1;
    bus.cmd_dir   = 2'd3;
    @(posedge clock_50);
    #1;
    waitReady("ready_after_first");
    @(posedge clock_50);
    #1;
    bus.cmd_valid = 1'b0;
    waitReady("ready_after_second");

    illegalVideo = 1'b1;
    applyStimulus(2'd3, 1'b0, 4, 6);
    illegalVideo = 1'b0;

    for (int i = 1; i <= 6; i++) applyStimulus(2'd0, 1'b1, 4, 6 - i);
    applyStimulus(2'd0, 1'b0, 4, 0);
    for (int i = 1; i <= 15; i++) applyStimulus(2'd3, 1'b1, 4 + i, 0);
    applyStimulus(2'd3, 1'b0, 19, 0);
    for (int i = 1; i <= 14; i++) applyStimulus(2'd1, 1'b1, 19, i);
    applyStimulus(2'd1, 1'b0, 19, 14);
    checkOutput("corner_tx", int'(bus.robot_tx), 19);
    checkOutput("corner_ty", int'(bus.robot_ty), 14);

    // Reset while waiting for vblank: pending move must vanish silently.
    @(negedge clock_50);
    bus.cmd_valid = 1'b1;
    bus.cmd_dir   = 2'd2;
    @(posedge clock_50);
    #1;
    bus.cmd_valid = 1'b0;
    ticks = 0;
    for (int i = 0; i < 200 && ticks < 2; i++) begin
      @(negedge clock_50);
      if (bus.frame_tick) ticks++;
    end
    if (ticks < 2) timeoutFail("wait_two_ticks");
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midrst_tx", int'(bus.robot_tx), 2);
    checkOutput("midrst_ty", int'(bus.robot_ty), 5);
    checkOutput("midrst_ready", int'(bus.cmd_ready), 1);
    checkOutput("midrst_done", int'(bus.move_done), 0);
    checkOutput("midrst_blocked", int'(bus.move_blocked), 0);
    @(posedge clock_50);
    @(negedge clock_50);
    reset = 1'b0;
    repeat (60) @(negedge clock_50);
    checkOutput("postrst_tx", int'(bus.robot_tx), 2);
    checkOutput("postrst_ty", int'(bus.robot_ty), 5);

    genOn = 1'b0;
    repeat (30) @(posedge clock_50);
    ticks = 0;
    misaligned = 0;
    for (int f = 0; f < 3; f++) begin
      for (int y = 0; y < 525; y++) begin
        @(posedge clock_50);
        #1;
        bus.pix_y    = 10'(y);
        bus.video_on = (y < 480);
        @(negedge clock_50);
        if (bus.frame_tick) begin
          ticks++;
          if (bus.pix_y != 10'd481) misaligned++;
        end
      end
    end
    checkOutput("sweep_ticks", ticks, 3);
    checkOutput("sweep_misaligned", misaligned, 0);
    checkOutput("scoreboard_empty", sbQ.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/robot_frame_ctrl.md
Name: robot_frame_ctrl

Overview:
- Schedules updates of the robot sprite position registers that the graphics renderer reads every pixel.
- Accepts move commands from the robot control logic through a valid/ready handshake, holding at most one pending command.
- Applies a move only during vertical blank, so the renderer never sees a position change mid-frame.
- Clamps every move to the tile grid and reports whether it was applied or blocked.

Parameters:
- MAX_X, 640, active pixels per line.
- MAX_Y, 480, active lines per frame; the start of vblank is the first pix_y >= MAX_Y.
- TILES_X, 20, grid width in tiles (32 px tiles).
- TILES_Y, 15, grid height in tiles.
- WALL_TX, 1, tile column that is impassable; moves into it are blocked.
- STEP_FRAMES, 4, minimum number of frames between two applied or blocked moves (1..15).
- INIT_TX, 0, reset tile column.
- INIT_TY, 0, reset tile row.

Ports:
- clock_50  in  1  system clock; all state is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- pix_y  in  10  current scan line from the sync generator.
- video_on  in  1  high while in the active display area.
- cmd_valid  in  1  move request present.
- cmd_dir  in  2  direction: 0 up, 1 down, 2 left, 3 right.
- cmd_ready  out  1  block can accept a command this cycle.
- robot_tx  out  5  current tile column.
- robot_ty  out  4  current tile row.
- move_done  out  1  one-cycle pulse: the pending move was applied.
- move_blocked  out  1  one-cycle pulse: the pending move was rejected.
- frame_tick  out  1  one-cycle pulse at each start of vblank.

Behaviour:
- Reset (async, immediate):
  - robot_tx=INIT_TX, robot_ty=INIT_TY.
  - cmd_ready=1; move_done, move_blocked, frame_tick = 0.
  - State IDLE, pending buffer empty, frame counter = 0.
  - Reset mid-move discards the pending command; no pulse is emitted.
- Vblank detect:
  - vb = (pix_y >= MAX_Y), registered into vb_q.
  - vb_start = vb & ~vb_q.
  - frame_tick is asserted the cycle after vb_start is computed (registered), so exactly one pulse per frame.
- Frame counter:
  - Increments on each frame_tick and saturates at STEP_FRAMES.
  - Clears to 0 when a move is applied or blocked.
- Handshake:
  - A transfer occurs when cmd_valid & cmd_ready are high on a clock edge; cmd_dir is latched into the pending buffer.
  - cmd_ready = 1 only in IDLE.
  - A command offered while cmd_ready=0 is not accepted; the source must hold it.
- State machine:
  - IDLE: on transfer -> WAIT_VB.
  - WAIT_VB: on frame_tick with frame counter >= STEP_FRAMES-1 (i.e. STEP_FRAMES frames elapsed including this one) -> APPLY; otherwise stay.
  - APPLY (1 cycle):
    - Compute the target tile. up: ty-1; down: ty+1; left: tx-1; right: tx+1.
    - Blocked if the target is outside 0..TILES_X-1 / 0..TILES_Y-1, or target tx == WALL_TX.
    - If not blocked, update robot_tx/ty and set move_done next cycle; otherwise leave the position unchanged and set move_blocked next cycle.
    - -> DONE.
  - DONE (1 cycle): the pulse is high; clear the frame counter -> IDLE (cmd_ready=1 the following cycle).
- Position outputs change only on the APPLY->DONE edge, which falls inside vblank (video_on=0).
  - If video_on=1 in APPLY (illegal timing), the move is still treated as blocked, not applied.
- Arithmetic:
  - Target computed in 6-bit signed form to detect underflow at 0.
  - No wrap-around: a left move at tx=0 is blocked; a down move at ty=TILES_Y-1 is blocked.
- Exclusivity and simultaneous events:
  - move_done and move_blocked are mutually exclusive and never high together with cmd_ready=1 in the same cycle.
  - frame_tick arriving in IDLE/APPLY/DONE only advances the frame counter.
  - cmd_valid held across DONE is accepted in the first IDLE cycle.

Test Plan:
- Reset with INIT_TX=0, INIT_TY=0, then cmd right (3) -> after STEP_FRAMES=4 frame_ticks, move_blocked pulses (tx=1 is the wall); robot_tx stays 0.
- Reset with INIT_TX=2, INIT_TY=5, cmd down -> after 4 frames, move_done pulses in vblank; robot_ty=6, robot_tx=2; cmd_ready is 0 from acceptance until the cycle after DONE.
- tx=2, ty=0, cmd up -> move_blocked; ty stays 0. tx=19, cmd right -> blocked; tx stays 19.
- Two back-to-back commands (right, right) from tx=2 with cmd_valid held -> first applied (tx=3), second accepted after DONE and applied 4 frames later (tx=4); exactly 2 move_done pulses.
- Assert reset while in WAIT_VB -> outputs return to INIT values immediately without a clock; no move_done/move_blocked; cmd_ready=1.
- Drive pix_y sweeping 0..524 across 3 frames -> exactly 3 frame_tick pulses, each one cycle wide, aligned to pix_y reaching 480.
